// File: rtl/eth_tx_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : eth_tx_sequencer_pkg
// Description : Shared types and constants for the Ethernet TX path
//               (sequencer FSM states, preamble/SFD bytes, FCS length).
//               Also used by the CRC and Wishbone FIFO side.
// Revision    : 1.0 - initial release
// ============================================================================
package eth_tx_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PREAMBLE = 3'd1,
    S_SFD      = 3'd2,
    S_FETCH    = 3'd3,
    S_LOAD     = 3'd4,
    S_SEND     = 3'd5,
    S_IFG      = 3'd6
  } eth_tx_state_t;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;
  localparam int         FCS_BYTES     = 4;
  localparam int         LEN_W         = 11;
  localparam int         REM_W         = 12;

  // A frame length is usable when it carries at least one payload byte and
  // does not exceed the configured maximum.
  function automatic logic len_is_valid(input logic [LEN_W-1:0] len,
                                        input logic [LEN_W-1:0] max_len);
    return (len != '0) && (len <= max_len);
  endfunction

endpackage
`default_nettype wire

// File: rtl/eth_tx_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : eth_tx_sequencer_if
// Description : Bundles the TX FIFO read port and the byte-wide MAC/PHY
//               stream of the TX sequencer. Signal prefixes are given from
//               the sequencer's point of view.
//   o_fifo_rd    : FIFO pop request
//   i_fifo_data  : FIFO read data, valid the cycle after o_fifo_rd
//   i_fifo_empty : FIFO empty flag
//   o_tx_data    : stream byte
//   o_tx_valid   : stream valid
//   o_tx_last    : marks the final FCS byte
//   i_tx_ready   : stream ready
//   master = sequencer side, slave = FIFO/PHY side
// Revision    : 1.0 - initial release
// ============================================================================
interface eth_tx_sequencer_if;

  logic       o_fifo_rd;
  logic [7:0] i_fifo_data;
  logic       i_fifo_empty;
  logic [7:0] o_tx_data;
  logic       o_tx_valid;
  logic       o_tx_last;
  logic       i_tx_ready;

  modport master (
    output o_fifo_rd,
    input  i_fifo_data,
    input  i_fifo_empty,
    output o_tx_data,
    output o_tx_valid,
    output o_tx_last,
    input  i_tx_ready
  );

  modport slave (
    input  o_fifo_rd,
    output i_fifo_data,
    output i_fifo_empty,
    input  o_tx_data,
    input  o_tx_valid,
    input  o_tx_last,
    output i_tx_ready
  );

endinterface
`default_nettype wire

// File: rtl/eth_tx_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : eth_tx_sequencer
// Description : Frame-level TX scheduler. On an accepted start it sends
//               PREAMBLE_LEN x 0x55 plus SFD, drains frame_len+4 bytes
//               (payload + FCS) from the TX FIFO to the byte stream, then
//               holds off for IFG_CYCLES. Sole reader of the TX FIFO.
//   clk          : system clock
//   rst          : synchronous active-high reset
//   i_start      : start pulse, honoured only when idle
//   i_frame_len  : payload length excluding FCS, sampled with i_start
//   bus          : FIFO read port + TX byte stream (master modport)
//   o_busy       : high from cycle after accepted start to end of IFG
//   o_done       : 1-cycle pulse after the last-byte handshake
//   o_underrun   : 1-cycle pulse when the frame is aborted on FIFO starvation
//   o_err        : 1-cycle pulse when a start is rejected for bad length
// Revision    : 1.0 - initial release
// ============================================================================
module eth_tx_sequencer
  import eth_tx_sequencer_pkg::*;
#(
  parameter int PREAMBLE_LEN    = 7,
  parameter int IFG_CYCLES      = 96,
  parameter int MAX_FRAME_LEN   = 1514,
  parameter int UNDERRUN_CYCLES = 64
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             i_start,
  input  wire logic [LEN_W-1:0] i_frame_len,
  eth_tx_sequencer_if.master    bus,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_underrun,
  output logic                  o_err
);

  localparam int c_pre_w = $clog2(PREAMBLE_LEN + 1);
  localparam int c_wd_w  = $clog2(UNDERRUN_CYCLES + 1);
  localparam int c_ifg_w = $clog2(IFG_CYCLES + 1);

  localparam logic [c_pre_w-1:0] c_pre_last = c_pre_w'(PREAMBLE_LEN - 1);
  localparam logic [c_wd_w-1:0]  c_wd_last  = c_wd_w'(UNDERRUN_CYCLES - 1);
  localparam logic [c_ifg_w-1:0] c_ifg_last = c_ifg_w'(IFG_CYCLES - 1);
  localparam logic [LEN_W-1:0]   c_max_len  = LEN_W'(MAX_FRAME_LEN);
  localparam logic [REM_W-1:0]   c_fcs      = REM_W'(FCS_BYTES);

  eth_tx_state_t      r_state;
  logic [REM_W-1:0]   r_remaining;
  logic [c_pre_w-1:0] r_pre_cnt;
  logic [c_wd_w-1:0]  r_wd_cnt;
  logic [c_ifg_w-1:0] r_ifg_cnt;
  logic [7:0]         r_tx_data;
  logic               r_tx_valid;
  logic               r_tx_last;
  logic               r_busy;
  logic               r_done;
  logic               r_underrun;
  logic               r_err;

  logic w_hs;
  logic w_len_ok;

  assign w_hs     = r_tx_valid && bus.i_tx_ready;
  assign w_len_ok = len_is_valid(i_frame_len, c_max_len);

  // Pop is combinational so the byte lands in S_LOAD one cycle later.
  assign bus.o_fifo_rd  = (r_state == S_FETCH) && !bus.i_fifo_empty;
  assign bus.o_tx_data  = r_tx_data;
  assign bus.o_tx_valid = r_tx_valid;
  assign bus.o_tx_last  = r_tx_last;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_underrun     = r_underrun;
  assign o_err          = r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_remaining <= '0;
      r_pre_cnt   <= '0;
      r_wd_cnt    <= '0;
      r_ifg_cnt   <= '0;
      r_tx_data   <= '0;
      r_tx_valid  <= 1'b0;
      r_tx_last   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_underrun  <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      // Status strobes default low so every assertion is a single cycle.
      r_done     <= 1'b0;
      r_underrun <= 1'b0;
      r_err      <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            if (w_len_ok) begin
              r_remaining <= {1'b0, i_frame_len} + c_fcs;
              r_tx_data   <= PREAMBLE_BYTE;
              r_tx_valid  <= 1'b1;
              r_tx_last   <= 1'b0;
              r_pre_cnt   <= '0;
              r_busy      <= 1'b1;
              r_state     <= S_PREAMBLE;
            end else begin
              r_err <= 1'b1;
            end
          end
        end

        S_PREAMBLE: begin
          if (w_hs) begin
            if (r_pre_cnt == c_pre_last) begin
              r_pre_cnt <= '0;
              r_tx_data <= SFD_BYTE;
              r_state   <= S_SFD;
            end else begin
              r_pre_cnt <= r_pre_cnt + 1'b1;
            end
          end
        end

        S_SFD: begin
          if (w_hs) begin
            r_tx_valid <= 1'b0;
            r_state    <= S_FETCH;
          end
        end

        S_FETCH: begin
          if (!bus.i_fifo_empty) begin
            r_wd_cnt <= '0;
            r_state  <= S_LOAD;
          end else if (r_wd_cnt == c_wd_last) begin
            // Starved too long: truncate the frame, still honour the IFG.
            r_wd_cnt   <= '0;
            r_underrun <= 1'b1;
            r_ifg_cnt  <= '0;
            r_state    <= S_IFG;
          end else begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
          end
        end

        S_LOAD: begin
          r_tx_data  <= bus.i_fifo_data;
          r_tx_valid <= 1'b1;
          r_tx_last  <= (r_remaining == REM_W'(1));
          r_state    <= S_SEND;
        end

        S_SEND: begin
          if (w_hs) begin
            r_remaining <= r_remaining - 1'b1;
            r_tx_valid  <= 1'b0;
            r_tx_last   <= 1'b0;
            if (r_remaining == REM_W'(1)) begin
              r_done    <= 1'b1;
              r_ifg_cnt <= '0;
              r_state   <= S_IFG;
            end else begin
              r_state <= S_FETCH;
            end
          end
        end

        S_IFG: begin
          if (r_ifg_cnt == c_ifg_last) begin
            r_ifg_cnt <= '0;
            r_busy    <= 1'b0;
            r_state   <= S_IDLE;
          end else begin
            r_ifg_cnt <= r_ifg_cnt + 1'b1;
          end
        end

        default: begin
          r_tx_valid <= 1'b0;
          r_tx_last  <= 1'b0;
          r_busy     <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_eth_tx_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_eth_tx_sequencer
// Description : Self-checking bench for eth_tx_sequencer. A queue-based FIFO
//               model feeds the DUT, a cycle collector records handshakes and
//               status pulses, and each scenario task compares against an
//               expected byte stream built from frame-level rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_eth_tx_sequencer;

  localparam int PRE  = 7;
  localparam int IFG  = 96;
  localparam int MAXL = 1514;
  localparam int UND  = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [10:0] frame_len;
  logic        busy, done, underrun, err;

  eth_tx_sequencer_if bus ();

  eth_tx_sequencer #(
    .PREAMBLE_LEN    (PRE),
    .IFG_CYCLES      (IFG),
    .MAX_FRAME_LEN   (MAXL),
    .UNDERRUN_CYCLES (UND)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .i_start     (start),
    .i_frame_len (frame_len),
    .bus         (bus),
    .o_busy      (busy),
    .o_done      (done),
    .o_underrun  (underrun),
    .o_err       (err)
  );

  always #5 clk = ~clk;

  // FIFO model: data appears the cycle after a pop.
  logic [7:0] fifo_q[$];
  logic [7:0] loaded[$];
  int         pop_count;

  always @(posedge clk) begin
    if (bus.o_fifo_rd === 1'b1 && fifo_q.size() > 0) begin
      bus.i_fifo_data <= fifo_q.pop_front();
      pop_count = pop_count + 1;
    end
  end

  always @(negedge clk) bus.i_fifo_empty = (fifo_q.size() == 0);

  // Collected observations
  logic [7:0] cap_data[$];
  bit         cap_last[$];
  int         cap_k[$];
  int         done_k[$], und_k[$], err_k[$];
  int         busy_first, end_k, stall_viol, diff_idx;
  logic       end_valid;

  // Expected stream
  logic [7:0] exp_data[$];
  bit         exp_last[$];

  int checks = 0;
  int errors = 0;

  task automatic load_fifo(input int n);
    logic [7:0] b;
    loaded.delete();
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      fifo_q.push_back(b);
      loaded.push_back(b);
    end
  endtask

  // Frame-level reference: preamble, SFD, then as many of the len+4 frame
  // bytes as the FIFO actually held; last only on byte len+4.
  function automatic void build_expected(input int len);
    int n;
    exp_data.delete();
    exp_last.delete();
    for (int i = 0; i < PRE; i++) begin
      exp_data.push_back(8'h55);
      exp_last.push_back(1'b0);
    end
    exp_data.push_back(8'hD5);
    exp_last.push_back(1'b0);
    n = (len + 4 < loaded.size()) ? len + 4 : loaded.size();
    for (int i = 0; i < n; i++) begin
      exp_data.push_back(loaded[i]);
      exp_last.push_back(i == len + 3);
    end
  endfunction

  function automatic int stream_diff();
    int d = 0;
    int m;
    diff_idx = -1;
    m = (cap_data.size() < exp_data.size()) ? cap_data.size() : exp_data.size();
    if (cap_data.size() != exp_data.size()) begin
      d = 1;
      diff_idx = m;
    end
    for (int i = 0; i < m; i++) begin
      if (cap_data[i] !== exp_data[i] || cap_last[i] !== exp_last[i]) begin
        d++;
        if (diff_idx < 0 || i < diff_idx) diff_idx = i;
      end
    end
    return d;
  endfunction

  task automatic drive_ready(input int mode);
    case (mode)
      0:       bus.i_tx_ready = 1'b1;
      1:       bus.i_tx_ready = ~bus.i_tx_ready;
      default: bus.i_tx_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  // Runs from posedge+1 until busy falls after having risen, or the budget
  // expires (end_k stays -1). k indexes negedge samples.
  task automatic collect(input bit do_start, input logic [10:0] len, input int mode,
                         input int max_cycles, input bit poke, input int rst_at);
    logic       pv, pr, pl;
    logic [7:0] pd;
    bit         seen;
    int         since_done;
    cap_data.delete(); cap_last.delete(); cap_k.delete();
    done_k.delete(); und_k.delete(); err_k.delete();
    busy_first = -1; end_k = -1; end_valid = 1'b0; stall_viol = 0; pop_count = 0;
    pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = 8'h00; seen = 1'b0; since_done = -1;
    start = do_start;
    frame_len = len;
    drive_ready(mode);
    for (int k = 0; k < max_cycles; k++) begin
      @(negedge clk);
      if (pv && !pr && (bus.o_tx_valid !== 1'b1 || bus.o_tx_data !== pd || bus.o_tx_last !== pl))
        stall_viol++;
      pv = bus.o_tx_valid; pr = bus.i_tx_ready; pd = bus.o_tx_data; pl = bus.o_tx_last;
      if (bus.o_tx_valid === 1'b1 && bus.i_tx_ready === 1'b1) begin
        cap_data.push_back(bus.o_tx_data);
        cap_last.push_back(bus.o_tx_last);
        cap_k.push_back(k);
      end
      if (since_done >= 0) since_done++;
      if (done === 1'b1) begin done_k.push_back(k); since_done = 0; end
      if (underrun === 1'b1) begin und_k.push_back(k); since_done = 0; end
      if (err === 1'b1) err_k.push_back(k);
      if (busy === 1'b1 && busy_first < 0) busy_first = k;
      if (busy === 1'b1) seen = 1'b1;
      else if (seen) begin
        end_k = k;
        end_valid = bus.o_tx_valid;
        break;
      end
      @(posedge clk); #1;
      start = 1'b0;
      rst = (k == rst_at);
      // Stray starts only where the DUT is certainly not idle.
      if (poke && (pv || (since_done >= 0 && since_done < 80))) begin
        start = 1'b1;
        frame_len = 11'($urandom_range(1, MAXL));
      end
      drive_ready(mode);
    end
    @(posedge clk); #1;
    start = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; frame_len = '0; bus.i_tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.o_tx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.o_tx_valid); end
    checks++; if (bus.o_tx_last !== 1'b0) begin errors++; $display("FAIL reset_last got %b exp 0", bus.o_tx_last); end
    checks++; if (bus.o_tx_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", bus.o_tx_data); end
    checks++; if ({busy, done, underrun, err} !== 4'b0000) begin errors++; $display("FAIL reset_status got %b exp 0000", {busy, done, underrun, err}); end
    checks++; if (bus.o_fifo_rd !== 1'b0) begin errors++; $display("FAIL reset_fifo_rd got %b exp 0", bus.o_fifo_rd); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_min_frame();
    int bad_gap;
    load_fifo(5);
    build_expected(1);
    collect(1'b1, 11'd1, 0, 400, 1'b0, -1);
    checks++; if (end_k < 0) begin errors++; $display("FAIL min_timeout frame did not finish within budget"); end
    checks++; if (busy_first !== 1) begin errors++; $display("FAIL min_busy_start got %0d exp 1", busy_first); end
    checks++; if (stream_diff() != 0) begin errors++; $display("FAIL min_stream first diff at %0d got %0d bytes exp %0d", diff_idx, cap_data.size(), exp_data.size()); end
    checks++; if (cap_k.size() == 0 || cap_k[0] != 1) begin errors++; $display("FAIL min_first_valid got k=%0d exp 1", (cap_k.size() > 0) ? cap_k[0] : -1); end
    checks++; if (done_k.size() != 1) begin errors++; $display("FAIL min_done_count got %0d exp 1", done_k.size()); end
    else begin
      checks++; if (done_k[0] != cap_k[cap_k.size()-1] + 1) begin errors++; $display("FAIL min_done_time got %0d exp %0d", done_k[0], cap_k[cap_k.size()-1] + 1); end
      checks++; if (end_k - done_k[0] != IFG) begin errors++; $display("FAIL min_ifg got %0d exp %0d", end_k - done_k[0], IFG); end
    end
    bad_gap = 0;
    for (int i = PRE + 1; i < cap_k.size(); i++) if (cap_k[i] - cap_k[i-1] != 3) bad_gap++;
    checks++; if (bad_gap != 0 || cap_k.size() != PRE + 6) begin errors++; $display("FAIL min_throughput got %0d bad gaps, %0d hs, exp 0 and %0d", bad_gap, cap_k.size(), PRE + 6); end
    checks++; if (pop_count != 5 || und_k.size() != 0 || err_k.size() != 0) begin errors++; $display("FAIL min_side got pops=%0d und=%0d err=%0d exp 5 0 0", pop_count, und_k.size(), err_k.size()); end
  endtask

  task automatic test_stall();
    load_fifo(64);
    build_expected(60);
    collect(1'b1, 11'd60, 1, 2000, 1'b0, -1);
    checks++; if (end_k < 0) begin errors++; $display("FAIL stall_timeout frame did not finish within budget"); end
    checks++; if (stall_viol != 0) begin errors++; $display("FAIL stall_hold got %0d unstable stalls exp 0", stall_viol); end
    checks++; if (cap_data.size() - PRE - 1 != 64) begin errors++; $display("FAIL stall_payload got %0d exp 64", cap_data.size() - PRE - 1); end
    checks++; if (stream_diff() != 0) begin errors++; $display("FAIL stall_stream first diff at %0d", diff_idx); end
    checks++; if (done_k.size() != 1) begin errors++; $display("FAIL stall_done got %0d exp 1", done_k.size()); end
  endtask

  task automatic test_underrun();
    load_fifo(6);
    build_expected(10);
    collect(1'b1, 11'd10, 0, 600, 1'b0, -1);
    checks++; if (end_k < 0) begin errors++; $display("FAIL und_timeout frame did not finish within budget"); end
    checks++; if (stream_diff() != 0) begin errors++; $display("FAIL und_stream first diff at %0d got %0d bytes exp %0d", diff_idx, cap_data.size(), exp_data.size()); end
    checks++; if (done_k.size() != 0) begin errors++; $display("FAIL und_no_done got %0d exp 0", done_k.size()); end
    checks++; if (und_k.size() != 1) begin errors++; $display("FAIL und_count got %0d exp 1", und_k.size()); end
    else begin
      checks++; if (und_k[0] - cap_k[cap_k.size()-1] != UND + 1) begin errors++; $display("FAIL und_delay got %0d exp %0d", und_k[0] - cap_k[cap_k.size()-1], UND + 1); end
      checks++; if (end_k - und_k[0] != IFG) begin errors++; $display("FAIL und_ifg got %0d exp %0d", end_k - und_k[0], IFG); end
    end
    checks++; if (pop_count != 6) begin errors++; $display("FAIL und_pops got %0d exp 6", pop_count); end
  endtask

  task automatic test_bad_len();
    int lens[2];
    lens[0] = 0;
    lens[1] = MAXL + 1;
    fifo_q.push_back(8'hA5);
    for (int j = 0; j < 2; j++) begin
      collect(1'b1, 11'(lens[j]), 0, 10, 1'b0, -1);
      checks++; if (err_k.size() != 1 || err_k[0] != 1) begin errors++; $display("FAIL bad_len_err len=%0d got %0d pulses exp 1 at k=1", lens[j], err_k.size()); end
      checks++; if (busy_first != -1 || cap_data.size() != 0) begin errors++; $display("FAIL bad_len_busy len=%0d got busy_k=%0d hs=%0d exp -1 0", lens[j], busy_first, cap_data.size()); end
      checks++; if (pop_count != 0) begin errors++; $display("FAIL bad_len_pop len=%0d got %0d exp 0", lens[j], pop_count); end
    end
    fifo_q.delete();
  endtask

  task automatic test_max_len();
    load_fifo(MAXL + 4);
    build_expected(MAXL);
    collect(1'b1, 11'(MAXL), 0, 5000, 1'b0, -1);
    checks++; if (end_k < 0) begin errors++; $display("FAIL max_timeout frame did not finish within budget"); end
    checks++; if (stream_diff() != 0 || done_k.size() != 1) begin errors++; $display("FAIL max_stream diff at %0d done=%0d exp done 1", diff_idx, done_k.size()); end
  endtask

  task automatic test_ignore_start();
    int len;
    len = $urandom_range(3, 12);
    load_fifo(len + 4);
    build_expected(len);
    collect(1'b1, 11'(len), 0, 600, 1'b1, -1);
    checks++; if (end_k < 0) begin errors++; $display("FAIL ign_timeout frame did not finish within budget"); end
    checks++; if (err_k.size() != 0) begin errors++; $display("FAIL ign_err got %0d pulses exp 0", err_k.size()); end
    checks++; if (stream_diff() != 0 || done_k.size() != 1) begin errors++; $display("FAIL ign_stream diff at %0d done=%0d exp 1", diff_idx, done_k.size()); end
    checks++; if (done_k.size() == 1 && end_k - done_k[0] != IFG) begin errors++; $display("FAIL ign_ifg got %0d exp %0d", end_k - done_k[0], IFG); end
    checks++; if (pop_count != len + 4) begin errors++; $display("FAIL ign_pops got %0d exp %0d", pop_count, len + 4); end
    // Next frame accepted once idle again.
    len = $urandom_range(1, 8);
    load_fifo(len + 4);
    build_expected(len);
    collect(1'b1, 11'(len), 0, 400, 1'b0, -1);
    checks++; if (busy_first != 1 || stream_diff() != 0) begin errors++; $display("FAIL ign_next busy_k=%0d diff at %0d exp 1 -1", busy_first, diff_idx); end
  endtask

  task automatic test_reset_mid();
    int nlast;
    load_fifo(24);
    collect(1'b1, 11'd20, 0, 200, 1'b0, 19);
    nlast = 0;
    foreach (cap_last[i]) if (cap_last[i]) nlast++;
    checks++; if (end_k != 21) begin errors++; $display("FAIL rst_busy_drop got k=%0d exp 21", end_k); end
    checks++; if (end_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", end_valid); end
    checks++; if (nlast != 0 || done_k.size() != 0) begin errors++; $display("FAIL rst_no_last got last=%0d done=%0d exp 0 0", nlast, done_k.size()); end
    fifo_q.delete();
    load_fifo(6);
    build_expected(2);
    collect(1'b1, 11'd2, 0, 400, 1'b0, -1);
    checks++; if (stream_diff() != 0 || busy_first != 1) begin errors++; $display("FAIL rst_next_stream diff at %0d busy_k=%0d", diff_idx, busy_first); end
    checks++; if (done_k.size() != 1 || end_k - done_k[0] != IFG) begin errors++; $display("FAIL rst_next_done got %0d pulses exp 1 with %0d IFG", done_k.size(), IFG); end
    fifo_q.delete();
  endtask

  task automatic test_random();
    int len;
    for (int f = 0; f < 4; f++) begin
      len = $urandom_range(1, 40);
      load_fifo(len + 4);
      build_expected(len);
      collect(1'b1, 11'(len), 2, (len + 12) * 20 + IFG + 200, 1'b0, -1);
      checks++; if (end_k < 0) begin errors++; $display("FAIL rnd_timeout frame %0d len=%0d", f, len); end
      checks++; if (stream_diff() != 0 || stall_viol != 0) begin errors++; $display("FAIL rnd_stream frame %0d len=%0d diff at %0d stalls=%0d", f, len, diff_idx, stall_viol); end
      checks++; if (done_k.size() != 1 || end_k - done_k[0] != IFG) begin errors++; $display("FAIL rnd_done frame %0d got %0d pulses exp 1", f, done_k.size()); end
    end
  endtask

  initial begin
    test_reset();
    test_min_frame();
    test_stall();
    test_underrun();
    test_bad_len();
    test_max_len();
    test_ignore_start();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
